// File: rtl/serial_parity_rx.sv
`default_nettype none
// ============================================================================
// Module   : serial_parity_rx
// Purpose  : Bit-serial frame receiver (start, DATA_W data bits LSB first,
//            parity, stop) with parity and framing error flags.
// Options  : SERIAL_PARITY_RX_ODD_EN -> odd parity (default even parity)
// Revision : 1.0 - initial release
// ============================================================================
module serial_parity_rx #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_in,
  input  logic              bit_en,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = (DATA_W < 2) ? 1 : $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

`ifdef SERIAL_PARITY_RX_ODD_EN
  // Seeding the accumulator with 1 flips the sense of the check to odd parity.
  localparam logic ACC_INIT = 1'b1;
`else
  localparam logic ACC_INIT = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                acc_q, acc_d;
  logic                perr_q, perr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                perr_out_q, perr_out_d;
  logic                ferr_q, ferr_d;

  // Next-state and datapath update; everything holds unless a bit strobe arrives.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    perr_d     = perr_q;
    data_d     = data_q;
    perr_out_d = perr_out_q;
    ferr_d     = ferr_q;
    valid_d    = 1'b0;
    if (bit_en) begin
      case (state_q)
        IDLE: begin
          if (!bit_in) begin
            state_d = DATA;
            cnt_d   = '0;
            acc_d   = ACC_INIT;
          end
        end
        DATA: begin
          // Right shift: after DATA_W strobes the first bit sits at position 0.
          shift_d = {bit_in, shift_q[DATA_W-1:1]};
          acc_d   = acc_q ^ bit_in;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          perr_d  = acc_q ^ bit_in;
          state_d = STOP;
        end
        STOP: begin
          state_d    = IDLE;
          data_d     = shift_q;
          perr_out_d = perr_q;
          ferr_d     = ~bit_in;
          valid_d    = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      acc_q      <= 1'b0;
      perr_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      perr_q     <= perr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_q     <= ferr_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign parity_err = perr_out_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_serial_parity_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_parity_rx
// Purpose  : Directed self-checking bench for serial_parity_rx.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_parity_rx;

  localparam int DATA_W = 8;
`ifdef SERIAL_PARITY_RX_ODD_EN
  localparam logic ODD = 1'b1;
`else
  localparam logic ODD = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic              bit_in;
  logic              bit_en;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_err;
  logic              frame_err;
  logic              busy;

  int tests = 0;
  int fails = 0;
  int vcount = 0;
  int vbase;

  serial_parity_rx #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_in     (bit_in),
    .bit_en     (bit_en),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count valid pulses; the value read at the edge is the previous cycle's.
  always @(posedge clk) begin
    if (data_valid === 1'b1) vcount++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One bit, preceded by gap-1 non-strobe cycles carrying random line noise.
  task automatic send_bit(input logic b, input int gap);
    for (int i = 1; i < gap; i++) begin
      @(negedge clk);
      bit_en = 1'b0;
      bit_in = 1'($urandom);
    end
    @(negedge clk);
    bit_en = 1'b1;
    bit_in = b;
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] d, input logic par, input logic stp,
                            input int gap, input bit with_start);
    if (with_start) send_bit(1'b0, gap);
    for (int k = 0; k < DATA_W; k++) begin
      send_bit(d[k], gap);
      if (k == 0) check("busy_in_frame", 32'(busy), 32'd1);
    end
    send_bit(par, gap);
    send_bit(stp, gap);
  endtask

  // Stop bit has just been driven: check the completion cycle and the one after.
  task automatic expect_frame(input string tag, input logic [DATA_W-1:0] d,
                              input logic pe, input logic fe);
    @(negedge clk);
    bit_en = 1'b0;
    bit_in = 1'b1;
    check({tag, "_valid"}, 32'(data_valid), 32'd1);
    check({tag, "_data"},  32'(data_out),   32'(d));
    check({tag, "_perr"},  32'(parity_err), 32'(pe));
    check({tag, "_ferr"},  32'(frame_err),  32'(fe));
    check({tag, "_busy"},  32'(busy),       32'd0);
    @(negedge clk);
    check({tag, "_pulse1"}, 32'(data_valid), 32'd0);
    check({tag, "_hold"},   32'(data_out),   32'(d));
  endtask

  initial begin
    rst_n  = 1'b0;
    bit_in = 1'b1;
    bit_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data",  32'(data_out),   32'd0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_perr",  32'(parity_err), 32'd0);
    check("rst_ferr",  32'(frame_err),  32'd0);
    check("rst_busy",  32'(busy),       32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Clean even-parity frame, continuous strobes.
    send_frame(8'hA5, 1'b0, 1'b1, 1, 1'b1);
    expect_frame("a5_clean", 8'hA5, 1'b0 ^ ODD, 1'b0);

    // Wrong parity bit.
    send_frame(8'hA5, 1'b1, 1'b1, 1, 1'b1);
    expect_frame("a5_perr", 8'hA5, 1'b1 ^ ODD, 1'b0);

    // 0x3C, then a start bit on the very next strobe (back-to-back).
    send_frame(8'h3C, 1'b0, 1'b1, 1, 1'b1);
    send_bit(1'b0, 1);
    check("b2b_valid", 32'(data_valid), 32'd1);
    check("b2b_data",  32'(data_out),   32'h3C);
    check("b2b_perr",  32'(parity_err), 32'(ODD));
    // Second frame of the pair: 0x0F with a stop bit of 0.
    send_frame(8'h0F, 1'b0, 1'b0, 1, 1'b0);
    expect_frame("0f_ferr", 8'h0F, ODD, 1'b1);

    // Break followed by a 0 seen in IDLE acts as a start bit.
    send_frame(8'h0F, 1'b0, 1'b0, 1, 1'b1);
    send_bit(1'b0, 1);
    check("brk_ferr", 32'(frame_err), 32'd1);
    send_frame(8'h3C, 1'b0, 1'b1, 1, 1'b0);
    expect_frame("after_brk", 8'h3C, ODD, 1'b0);

    // Strobe every 4th cycle with noise between strobes.
    vbase = vcount;
    send_frame(8'h81, 1'b0, 1'b1, 4, 1'b1);
    expect_frame("gap81", 8'h81, ODD, 1'b0);
    check("gap81_count", 32'(vcount - vbase), 32'd1);

    // Abort after three data bits of 0x55.
    vbase = vcount;
    send_bit(1'b0, 1);
    send_bit(1'b1, 1);
    send_bit(1'b0, 1);
    send_bit(1'b1, 1);
    @(negedge clk);
    bit_en = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    check("abort_busy",  32'(busy),       32'd0);
    check("abort_valid", 32'(data_valid), 32'd0);
    check("abort_data",  32'(data_out),   32'd0);
    check("abort_perr",  32'(parity_err), 32'd0);
    send_frame(8'h55, 1'b0, 1'b1, 1, 1'b1);
    expect_frame("r55", 8'h55, ODD, 1'b0);
    check("r55_count", 32'(vcount - vbase), 32'd1);

    // Idle line with strobes: never starts a frame.
    vbase = vcount;
    for (int i = 0; i < 20; i++) begin
      send_bit(1'b1, 1);
      if (i > 0) check("idle_busy", 32'(busy), 32'd0);
    end
    @(negedge clk);
    bit_en = 1'b0;
    check("idle_busy_end", 32'(busy), 32'd0);
    @(negedge clk);
    check("idle_count", 32'(vcount - vbase), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
